// File: rtl/counter_event_pkg.sv
// Shared state encoding and default sizing for counter_event_capture.
package counter_event_pkg;

  localparam int NUM_EVT = 3;
  localparam int CNT_W   = 16;
  localparam int TS_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/event_sat_counter.sv
// One saturating event counter with a sticky overflow flag; clr restarts the
// window and still counts an event that lands in the same cycle.
module event_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= CNT_W'(inc);
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) begin
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_event_capture.sv
// Per-event live counters with a req/ack snapshot handshake to the host.
// Optional first-event timestamp is built only when EVENT_TIMESTAMP_EN is defined.
module counter_event_capture
  import counter_event_pkg::*;
#(
  parameter int NUM_EVT = counter_event_pkg::NUM_EVT,
  parameter int CNT_W   = counter_event_pkg::CNT_W,
  parameter int TS_W    = counter_event_pkg::TS_W
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_EVT-1:0]       evt_in,
  input  logic                     snap_req,
  output logic                     snap_ack,
  output logic [NUM_EVT*CNT_W-1:0] snap_cnt,
  output logic [NUM_EVT-1:0]       snap_ovf,
  output logic [TS_W-1:0]          snap_ts,
  output logic                     evt_pending
);

  state_t state, state_nxt;
  logic   copy;

  logic [NUM_EVT-1:0][CNT_W-1:0] live_cnt;
  logic [NUM_EVT-1:0]            live_ovf;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ACK holds until the request drops, so a level held high copies only once.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snap_req) state_nxt = COPY;
      COPY:    state_nxt = ACK;
      ACK:     if (!snap_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    snap_ack = (state == ACK);
    copy     = (state == COPY);
  end

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_cnt
    event_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk(sys_clk),
      .rst(reset),
      .clr(copy),
      .inc(enable & evt_in[g]),
      .cnt(live_cnt[g]),
      .ovf(live_ovf[g])
    );
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      evt_pending <= 1'b0;
      snap_cnt    <= '0;
      snap_ovf    <= '0;
    end else begin
      evt_pending <= |live_cnt;
      if (copy) begin
        snap_cnt <= live_cnt;
        snap_ovf <= live_ovf;
      end
    end
  end

`ifdef EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_ctr;
  logic [TS_W-1:0] first_ts;
  logic            first_seen;
  logic            any_evt;

  assign any_evt = enable & (|evt_in);

  // A window with no events reports all-ones so it cannot alias timestamp 0.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ts_ctr     <= '0;
      first_ts   <= '0;
      first_seen <= 1'b0;
      snap_ts    <= '0;
    end else begin
      ts_ctr <= ts_ctr + TS_W'(1);
      if (copy) begin
        snap_ts    <= first_seen ? first_ts : '1;
        first_seen <= any_evt;
        first_ts   <= ts_ctr;
      end else if (any_evt && !first_seen) begin
        first_seen <= 1'b1;
        first_ts   <= ts_ctr;
      end
    end
  end
`else
  assign snap_ts = '0;
`endif

endmodule

// File: doc/counter_event_capture.md
COUNTER_EVENT_CAPTURE -- requirements
Module: counter_event_capture

Interface
REQ-001 The block SHALL have parameter NUM_EVT, default 3, giving the number of single-cycle event inputs (count1eq00, count1eq80, count2eqFF).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of each per-event count.
REQ-003 The block SHALL have parameter TS_W, default 32, giving the width of the timestamp.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: when low, events are ignored.
REQ-007 The block SHALL have port evt_in, input, NUM_EVT bits: event pulses from the counter stage.
REQ-008 The block SHALL have port snap_req, input, 1 bit: level request from the host-facing wire-in.
REQ-009 The block SHALL have port snap_ack, output, 1 bit: high while the snapshot is valid.
REQ-010 The block SHALL have port snap_cnt, output, NUM_EVT*CNT_W bits: snapshot counts, with event i in bits [i*CNT_W +: CNT_W].
REQ-011 The block SHALL have port snap_ovf, output, NUM_EVT bits: per-event saturation flags for the snapshot.
REQ-012 The block SHALL have port snap_ts, output, TS_W bits: timestamp of the first event in the snapshot window.
REQ-013 The block SHALL have port evt_pending, output, 1 bit: high when any live count is nonzero.

Function
REQ-014 Each live counter SHALL increment by 1 in a cycle where evt_in[i]=1 and enable=1; simultaneous events on different inputs SHALL all count in the same cycle.
REQ-015 A live counter at all-ones SHALL hold its value, and an event arriving while it is held SHALL set that counter's sticky live overflow flag.
REQ-016 The state machine SHALL have states IDLE, COPY and ACK, encoded as a 2-bit value.
REQ-017 In IDLE, when snap_req=1 the block SHALL go to COPY.
REQ-018 In COPY (exactly one cycle), the live counts, overflow flags and first-timestamp SHALL be copied to the snapshot registers, and the live counts, flags and first-seen flag SHALL be cleared. An event occurring in the COPY cycle SHALL be counted as 1 in the new window and SHALL be absent from the snapshot.
REQ-019 In ACK, snap_ack SHALL be 1 and SHALL stay 1 until snap_req=0, at which point the block SHALL go to IDLE; snap_ack SHALL therefore first rise 2 cycles after the snap_req rising edge is sampled.
REQ-020 snap_cnt, snap_ovf and snap_ts SHALL be stable from COPY exit until the next COPY.
REQ-021 evt_pending SHALL be registered and SHALL reflect the live counts with 1-cycle latency.
REQ-022 A snap_req that is held high across ACK SHALL NOT retrigger a copy; a new copy requires snap_req to return low first.

Reset
REQ-023 On reset assertion the block SHALL immediately enter IDLE and clear all counts, flags, snapshots and the timestamp.
REQ-024 On reset assertion snap_ack and evt_pending SHALL be 0.
REQ-025 A reset asserted mid-handshake (during COPY or ACK) SHALL abandon the snapshot with all snapshot outputs set to 0.

Configuration
REQ-026 With EVENT_TIMESTAMP_EN defined, the block SHALL contain a free-running TS_W timestamp counter that wraps to 0.
REQ-027 With EVENT_TIMESTAMP_EN defined, the first event after a clear (or after reset) SHALL latch that cycle's counter value.
REQ-028 With EVENT_TIMESTAMP_EN defined, a window with no events SHALL report snap_ts as all-ones.
REQ-029 With EVENT_TIMESTAMP_EN undefined, snap_ts SHALL be constant 0 and the timestamp logic SHALL be absent.

Structure
REQ-030 The package counter_event_pkg SHALL hold the state enum (IDLE, COPY, ACK) and the default constants NUM_EVT, CNT_W and TS_W.
REQ-031 The sub-module event_sat_counter SHALL provide one saturating counter plus its sticky overflow flag with a synchronous clear, and SHALL be instantiated NUM_EVT times.

Verification
REQ-032 Scenario: 5 pulses on evt_in[0] and 2 on evt_in[2], then snap_req -> snap_cnt = {16'd2, 16'd0, 16'd5}, snap_ovf = 0, snap_ack high at cycle +2.
REQ-033 Scenario: CNT_W=4 with 17 pulses on evt_in[1] -> count 4'hF and snap_ovf[1]=1; the next snapshot, with no events, gives count 0 and ovf 0.
REQ-034 Scenario: evt_in=3'b111 in the COPY cycle -> all snapshot counts exclude it; the next snapshot gives 1 for each input.
REQ-035 Scenario: enable=0 with 10 pulses -> snapshot counts all 0, evt_pending stays 0, and snap_ts = all-ones (macro defined).
REQ-036 Scenario: reset pulsed while in ACK -> snap_ack=0 the same cycle and all snapshot outputs 0; a following request after 3 events on input 0 gives count 3.
REQ-037 Scenario: first event at timestamp 100, snap_req held high for 20 cycles -> exactly one copy occurs and snap_ts=100; with the macro undefined, snap_ts=0.
